// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// State encoding, opcode values and instruction/PC geometry.
package fetch_unit_pkg;

    localparam int          ILEN    = 16;
    localparam logic [15:0] PC_STEP = 16'd2;

    localparam logic [3:0]  OP_HLT  = 4'hF;
    localparam logic [3:0]  OP_B    = 4'hC;
    localparam logic [3:0]  OP_BR   = 4'hD;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN,
        HOLD,
        HALT
    } fstate_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, one-outstanding imem request,
// output buffer to decode, execute redirects and HLT stop.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [15:0]     imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst_data,
    output logic [15:0]     inst_pc,
    output logic [15:0]     inst_pc_plus2,
    input  logic            redirect_valid,
    input  logic [15:0]     redirect_pc,
    output logic            halted
);

    localparam logic [15:0] PC_INIT = {RESET_PC[15:1], 1'b0};

    fstate_t     state;
    logic [15:0] pc;
    logic        req_fire;
    logic        is_hlt;

    assign req_fire       = (state == REQ) && imem_req_ready;
    assign is_hlt         = (inst_data[15:12] == OP_HLT);

    assign imem_req_valid = (state == REQ);
    assign imem_req_addr  = pc;
    assign inst_valid     = (state == HOLD);
    assign halted         = (state == HALT);

    // Fetch sequencer: redirect wins over every other event in a cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            pc            <= PC_INIT;
            inst_data     <= '0;
            inst_pc       <= '0;
            inst_pc_plus2 <= '0;
        end else if (redirect_valid) begin
            pc <= {redirect_pc[15:1], 1'b0};
            unique case (state)
                REQ:     state <= req_fire ? DRAIN : REQ;
                WAIT:    state <= imem_rsp_valid ? REQ : DRAIN;
                DRAIN:   state <= DRAIN;
                default: state <= REQ;
            endcase
        end else begin
            unique case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (imem_req_ready) state <= WAIT;
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        inst_data     <= imem_rsp_data;
                        inst_pc       <= pc;
                        inst_pc_plus2 <= pc + PC_STEP;
                        state         <= HOLD;
                    end
                end
                DRAIN: begin
                    if (imem_rsp_valid) state <= REQ;
                end
                HOLD: begin
                    if (inst_ready) begin
                        if (is_hlt) begin
                            state <= HALT;
                        end else begin
                            pc    <= pc + PC_STEP;
                            state <= REQ;
                        end
                    end
                end
                HALT:    state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, backpressure,
// redirects, HLT and PC wrap, with a small latency memory model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_ready = 1'b1;
    logic        imem_rsp_valid = 1'b0;
    logic [15:0] imem_rsp_data = 16'h0;
    logic        inst_ready = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0;

    logic        req_valid, inst_valid, halted;
    logic [15:0] req_addr, inst_data, inst_pc, inst_pc2;

    logic        req_valid2, inst_valid2, halted2;
    logic [15:0] req_addr2, inst_data2, inst_pc2_b, inst_pc2_2;

    int errors = 0;
    int checks = 0;
    int lat = 1;

    logic [15:0] hold_data, hold_pc, hold_pc2;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(16'h0010)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst_data(inst_data),
        .inst_pc(inst_pc), .inst_pc_plus2(inst_pc2),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halted(halted)
    );

    fetch_unit #(.RESET_PC(16'hFFFE)) dut2 (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_valid2), .imem_req_ready(imem_req_ready),
        .imem_req_addr(req_addr2), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid2),
        .inst_ready(inst_ready), .inst_data(inst_data2),
        .inst_pc(inst_pc2_b), .inst_pc_plus2(inst_pc2_2),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halted(halted2)
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'h0020) return 16'hF000;
        return {4'h1, a[11:0]};
    endfunction

    // Memory model: a request seen valid&ready at a negedge is
    // accepted at the next posedge; the response is driven lat
    // negedges later so the DUT samples it lat cycles after acceptance.
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [15:0] paddr = 16'h0;
    always @(negedge clk) begin
        if (rst) begin
            pend = 1'b0;
            imem_rsp_valid = 1'b0;
        end else begin
            imem_rsp_valid = 1'b0;
            if (pend) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data = mem_word(paddr);
                    pend = 1'b0;
                end
            end
            if (!pend && req_valid && imem_req_ready) begin
                pend = 1'b1;
                cnt = lat;
                paddr = req_addr;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %b want 0", req_valid); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_inst_valid got %b want 0", inst_valid); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %b want 0", halted); end
        checks++; if (inst_data !== 16'h0) begin errors++; $display("FAIL rst_inst_data got %h want 0000", inst_data); end
        checks++; if (inst_pc !== 16'h0) begin errors++; $display("FAIL rst_inst_pc got %h want 0000", inst_pc); end
        checks++; if (inst_pc2 !== 16'h0) begin errors++; $display("FAIL rst_inst_pc_plus2 got %h want 0000", inst_pc2); end
        rst = 1'b0;
        tick();
        checks++; if (req_valid !== 1'b1 || req_addr !== 16'h0010) begin errors++; $display("FAIL first_req got %b/%h want 1/0010", req_valid, req_addr); end
    endtask

    task automatic test_stream();
        logic [15:0] a;
        inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 16'h0010 + 16'(2 * i);
            checks++; if (req_valid !== 1'b1 || req_addr !== a) begin errors++; $display("FAIL stream_req%0d got %b/%h want 1/%h", i, req_valid, req_addr, a); end
            checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL stream_iv_req%0d got %b want 0", i, inst_valid); end
            tick();
            checks++; if (req_valid !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL stream_wait%0d got %b/%b want 0/0", i, req_valid, inst_valid); end
            tick();
            checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL stream_iv%0d got %b want 1", i, inst_valid); end
            checks++; if (inst_pc !== a || inst_data !== mem_word(a)) begin errors++; $display("FAIL stream_buf%0d got %h/%h want %h/%h", i, inst_pc, inst_data, a, mem_word(a)); end
            checks++; if (inst_pc2 !== a + 16'd2) begin errors++; $display("FAIL stream_pc2_%0d got %h want %h", i, inst_pc2, a + 16'd2); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        inst_ready = 1'b0;
        checks++; if (req_addr !== 16'h0016) begin errors++; $display("FAIL bp_req got %h want 0016", req_addr); end
        tick();
        tick();
        hold_data = inst_data;
        hold_pc = inst_pc;
        hold_pc2 = inst_pc2;
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 16'h0016) begin errors++; $display("FAIL bp_hold got %b/%h want 1/0016", inst_valid, inst_pc); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (inst_valid !== 1'b1 || req_valid !== 1'b0) begin errors++; $display("FAIL bp_stall%0d got iv=%b rv=%b want 1/0", i, inst_valid, req_valid); end
            checks++; if (inst_data !== 16'h1016 || inst_pc !== 16'h0016 || inst_pc2 !== 16'h0018) begin errors++; $display("FAIL bp_data%0d got %h/%h/%h want 1016/0016/0018", i, inst_data, inst_pc, inst_pc2); end
        end
        inst_ready = 1'b1;
        tick();
        checks++; if (req_valid !== 1'b1 || req_addr !== 16'h0018) begin errors++; $display("FAIL bp_after got %b/%h want 1/0018", req_valid, req_addr); end
    endtask

    task automatic test_redirect_wait();
        lat = 3;
        tick();
        checks++; if (req_valid !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL rw_wait got %b/%b want 0/0", req_valid, inst_valid); end
        redirect_valid = 1'b1;
        redirect_pc = 16'h0041;
        tick();
        redirect_valid = 1'b0;
        lat = 1;
        checks++; if (req_valid !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL rw_drain1 got %b/%b want 0/0", req_valid, inst_valid); end
        tick();
        checks++; if (req_valid !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL rw_drain2 got %b/%b want 0/0", req_valid, inst_valid); end
        tick();
        checks++; if (req_valid !== 1'b1 || req_addr !== 16'h0040) begin errors++; $display("FAIL rw_req got %b/%h want 1/0040", req_valid, req_addr); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rw_stale_iv got %b want 0", inst_valid); end
        tick();
        tick();
        checks++; if (inst_valid !== 1'b1 || inst_pc !== 16'h0040 || inst_data !== 16'h1040) begin errors++; $display("FAIL rw_new got %b/%h/%h want 1/0040/1040", inst_valid, inst_pc, inst_data); end
    endtask

    task automatic test_redirect_hold();
        inst_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 16'h0080;
        tick();
        redirect_valid = 1'b0;
        checks++; if (req_valid !== 1'b1 || req_addr !== 16'h0080) begin errors++; $display("FAIL rh_req got %b/%h want 1/0080", req_valid, req_addr); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rh_iv got %b want 0", inst_valid); end
        tick();
        tick();
        checks++; if (inst_pc !== 16'h0080 || inst_pc2 !== 16'h0082) begin errors++; $display("FAIL rh_buf got %h/%h want 0080/0082", inst_pc, inst_pc2); end
    endtask

    task automatic test_halt();
        redirect_valid = 1'b1;
        redirect_pc = 16'h0020;
        tick();
        redirect_valid = 1'b0;
        checks++; if (req_valid !== 1'b1 || req_addr !== 16'h0020) begin errors++; $display("FAIL hlt_req got %b/%h want 1/0020", req_valid, req_addr); end
        tick();
        tick();
        checks++; if (inst_valid !== 1'b1 || inst_data !== 16'hF000) begin errors++; $display("FAIL hlt_word got %b/%h want 1/F000", inst_valid, inst_data); end
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++; if (halted !== 1'b1 || req_valid !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL hlt_stop%0d got h=%b rv=%b iv=%b want 1/0/0", i, halted, req_valid, inst_valid); end
            tick();
        end
        redirect_valid = 1'b1;
        redirect_pc = 16'h0100;
        tick();
        redirect_valid = 1'b0;
        checks++; if (halted !== 1'b0 || req_valid !== 1'b1 || req_addr !== 16'h0100) begin errors++; $display("FAIL hlt_resume got h=%b rv=%b a=%h want 0/1/0100", halted, req_valid, req_addr); end
        tick();
        tick();
        checks++; if (inst_pc !== 16'h0100 || inst_data !== 16'h1100) begin errors++; $display("FAIL hlt_fetch got %h/%h want 0100/1100", inst_pc, inst_data); end
    endtask

    task automatic test_wrap();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        inst_ready = 1'b1;
        tick();
        checks++; if (req_valid2 !== 1'b1 || req_addr2 !== 16'hFFFE) begin errors++; $display("FAIL wrap_req0 got %b/%h want 1/FFFE", req_valid2, req_addr2); end
        tick();
        tick();
        checks++; if (inst_pc2_b !== 16'hFFFE || inst_pc2_2 !== 16'h0000) begin errors++; $display("FAIL wrap_buf got %h/%h want FFFE/0000", inst_pc2_b, inst_pc2_2); end
        tick();
        checks++; if (req_valid2 !== 1'b1 || req_addr2 !== 16'h0000) begin errors++; $display("FAIL wrap_req1 got %b/%h want 1/0000", req_valid2, req_addr2); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_hold();
        test_halt();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
